// File: rtl/gpioemu_mulpop_pkg.sv
// Shared definitions for the gpioemu multiply + popcount peripheral:
// register offsets, CSR bit positions, FSM states and a popcount helper.
package gpioemu_mulpop_pkg;

  localparam logic [15:0] OFF_A1  = 16'h0000;
  localparam logic [15:0] OFF_A2  = 16'h0008;
  localparam logic [15:0] OFF_W   = 16'h0010;
  localparam logic [15:0] OFF_L   = 16'h0018;
  localparam logic [15:0] OFF_CSR = 16'h0020;

  localparam int CSR_VALID_BIT = 0;
  localparam int CSR_BUSY_BIT  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MULT  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/gpioemu_mulpop_if.sv
// Host-side register bus of the gpioemu system, shared by the peripheral and its host.
interface gpioemu_mulpop_if;
  // Strobes are level signals synchronous to clk; the slave acts once per 0->1
  // transition of srd/swr, sampling saddress/sdata_in on that edge. sdata_out is
  // registered and changes only in the cycle after a read edge.
  logic [15:0] saddress;
  logic        srd;
  logic        swr;
  logic [31:0] sdata_in;
  logic [31:0] sdata_out;

  modport master (output saddress, output srd, output swr, output sdata_in, input sdata_out);
  modport slave  (input saddress, input srd, input swr, input sdata_in, output sdata_out);
endinterface

// File: rtl/gpioemu_mulpop_shift_mul.sv
// Sequential shift-add multiplier: operands latched on start_i, one multiplier
// bit consumed per cycle (LSB first), product valid after OP_W steps.
module gpioemu_mulpop_shift_mul #(
  parameter int OP_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  output logic [2*OP_W-1:0] prod_o,
  output logic              last_o
);

  localparam int CW = $clog2(OP_W + 1);

  logic [2*OP_W-1:0] mcand_q;
  logic [2*OP_W-1:0] acc_q;
  logic [OP_W-1:0]   mplier_q;
  logic [CW-1:0]     cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start_i) begin
      mcand_q  <= {{OP_W{1'b0}}, a_i};
      acc_q    <= '0;
      mplier_q <= b_i;
      cnt_q    <= CW'(OP_W);
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
    end
  end

  // High during the cycle whose closing edge performs the final step.
  assign last_o = (cnt_q == CW'(1));
  assign prod_o = acc_q;

endmodule

// File: rtl/gpioemu_mulpop.sv
// Bus-mapped multiply + popcount peripheral. Optional interrupt output is
// enabled by defining GPIOEMU_MULPOP_IRQ_EN.
module gpioemu_mulpop
  import gpioemu_mulpop_pkg::*;
#(
  parameter int          OP_W  = 24,
  parameter int          RES_W = 32,
  parameter int          CNT_W = 16,
  parameter logic [15:0] BASE  = 16'h0380
) (
  input  logic              clk,
  input  logic              reset,
  gpioemu_mulpop_if.slave   bus,
  input  logic [31:0]       gpio_in,
  input  logic              gpio_latch,
  output logic [31:0]       gpio_out,
  output logic [31:0]       gpio_in_s_insp,
  output state_e            dbg_state_o
`ifdef GPIOEMU_MULPOP_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam logic [15:0] ADDR_A1  = BASE + OFF_A1;
  localparam logic [15:0] ADDR_A2  = BASE + OFF_A2;
  localparam logic [15:0] ADDR_W   = BASE + OFF_W;
  localparam logic [15:0] ADDR_L   = BASE + OFF_L;
  localparam logic [15:0] ADDR_CSR = BASE + OFF_CSR;

  state_e            state_q;
  logic              srd_q, swr_q;
  logic [31:0]       sdata_out_q;
  logic [31:0]       gpio_in_s_q;
  logic [OP_W-1:0]   a1_q, a2_q;
  logic [RES_W-1:0]  w_q;
  logic [5:0]        l_q;
  logic              valid_q;
  logic [5:0]        pop_q;
  logic              ovf_q;
  logic [CNT_W-1:0]  op_cnt_q;
  logic [31:0]       rd_data_d;
  logic              rd_edge, wr_edge, start_acc, busy;
  logic [2*OP_W-1:0] mul_prod;
  logic              mul_last;
  logic              unused_sdata_hi;

  assign rd_edge   = bus.srd & ~srd_q;
  assign wr_edge   = bus.swr & ~swr_q;
  assign busy      = (state_q != ST_IDLE);
  assign start_acc = wr_edge && (bus.saddress == ADDR_CSR) && (state_q == ST_IDLE);
  assign unused_sdata_hi = ^bus.sdata_in[31:OP_W];

  gpioemu_mulpop_shift_mul #(.OP_W(OP_W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start_i (start_acc),
    .a_i     (a1_q),
    .b_i     (a2_q),
    .prod_o  (mul_prod),
    .last_o  (mul_last)
  );

  // Read mux sees register values before any same-cycle write lands.
  always_comb begin
    rd_data_d = '0;
    if (bus.saddress == ADDR_A1) begin
      rd_data_d = 32'(a1_q);
    end else if (bus.saddress == ADDR_A2) begin
      rd_data_d = 32'(a2_q);
    end else if (bus.saddress == ADDR_W) begin
      rd_data_d = 32'(w_q);
    end else if (bus.saddress == ADDR_L) begin
      rd_data_d = 32'(l_q);
    end else if (bus.saddress == ADDR_CSR) begin
      rd_data_d[CSR_BUSY_BIT]  = busy;
      rd_data_d[CSR_VALID_BIT] = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      srd_q       <= 1'b0;
      swr_q       <= 1'b0;
      sdata_out_q <= '0;
      gpio_in_s_q <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      w_q         <= '0;
      l_q         <= '0;
      valid_q     <= 1'b1;
      pop_q       <= '0;
      ovf_q       <= 1'b0;
      op_cnt_q    <= '0;
    end else begin
      srd_q <= bus.srd;
      swr_q <= bus.swr;
      if (gpio_latch) gpio_in_s_q <= gpio_in;
      if (rd_edge) sdata_out_q <= rd_data_d;
      if (wr_edge && bus.saddress == ADDR_A1) a1_q <= bus.sdata_in[OP_W-1:0];
      if (wr_edge && bus.saddress == ADDR_A2) a2_q <= bus.sdata_in[OP_W-1:0];
      case (state_q)
        ST_IDLE: begin
          if (start_acc) state_q <= ST_MULT;
        end
        ST_MULT: begin
          if (mul_last) state_q <= ST_COUNT;
        end
        ST_COUNT: begin
          pop_q   <= popcount32(32'(mul_prod[RES_W-1:0]));
          ovf_q   <= ((mul_prod >> RES_W) != '0);
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          // Results become visible all at once so readers never see partial values.
          w_q      <= mul_prod[RES_W-1:0];
          l_q      <= pop_q;
          valid_q  <= ~ovf_q;
          op_cnt_q <= op_cnt_q + CNT_W'(1);
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef GPIOEMU_MULPOP_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else if (state_q == ST_DONE) begin
      irq_q <= 1'b1;
    end else if (rd_edge && bus.saddress == ADDR_CSR) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`endif

  assign bus.sdata_out   = sdata_out_q;
  assign gpio_out        = 32'(op_cnt_q);
  assign gpio_in_s_insp  = gpio_in_s_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_gpioemu_mulpop.sv
// Bench for gpioemu_mulpop: randomized bus traffic against a cycle-level
// reference model, plus literal expectations for the documented scenarios.
module tb_gpioemu_mulpop;
  import gpioemu_mulpop_pkg::*;

  localparam int          OP_W  = 24;
  localparam int          RES_W = 32;
  localparam int          CNT_W = 4;
  localparam logic [15:0] BASE  = 16'h0380;
  localparam logic [15:0] AD_A1  = BASE + 16'h0000;
  localparam logic [15:0] AD_A2  = BASE + 16'h0008;
  localparam logic [15:0] AD_W   = BASE + 16'h0010;
  localparam logic [15:0] AD_L   = BASE + 16'h0018;
  localparam logic [15:0] AD_CSR = BASE + 16'h0020;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic [31:0] gpio_in;
  logic        gpio_latch;
  logic [31:0] gpio_out;
  logic [31:0] gpio_in_s_insp;
  state_e      dbg_state;
`ifdef GPIOEMU_MULPOP_IRQ_EN
  logic        irq;
`endif

  gpioemu_mulpop_if bus ();

  gpioemu_mulpop #(.OP_W(OP_W), .RES_W(RES_W), .CNT_W(CNT_W), .BASE(BASE)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus.slave),
    .gpio_in        (gpio_in),
    .gpio_latch     (gpio_latch),
    .gpio_out       (gpio_out),
    .gpio_in_s_insp (gpio_in_s_insp),
    .dbg_state_o    (dbg_state)
`ifdef GPIOEMU_MULPOP_IRQ_EN
    ,
    .irq            (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [OP_W-1:0] m_a1, m_a2;
  logic [31:0]     m_w, m_l, m_rdata, m_gpio_s;
  logic [63:0]     m_prod;
  bit              m_valid, m_busy, m_prev_rd, m_prev_wr;
  int              m_cnt, m_t;
`ifdef GPIOEMU_MULPOP_IRQ_EN
  bit              m_irq;
`endif

  function automatic logic [31:0] model_read(input logic [15:0] a);
    if (a == AD_A1) return 32'(m_a1);
    if (a == AD_A2) return 32'(m_a2);
    if (a == AD_W) return m_w;
    if (a == AD_L) return m_l;
    if (a == AD_CSR) return {30'b0, m_busy, m_valid};
    return 32'h0;
  endfunction

  // Start accepted at edge N: MULT for the next OP_W cycles, then COUNT, DONE,
  // results land on edge N+OP_W+2.
  function automatic state_e model_state();
    if (!m_busy) return ST_IDLE;
    if (m_t < OP_W) return ST_MULT;
    if (m_t == OP_W) return ST_COUNT;
    return ST_DONE;
  endfunction

  always @(posedge clk) begin
    bit rd_e, wr_e, pre_busy;
    if (reset) begin
      m_a1 = '0; m_a2 = '0; m_w = '0; m_l = '0; m_rdata = '0; m_gpio_s = '0;
      m_prod = '0; m_valid = 1'b1; m_busy = 1'b0; m_prev_rd = 1'b0; m_prev_wr = 1'b0;
      m_cnt = 0; m_t = 0;
`ifdef GPIOEMU_MULPOP_IRQ_EN
      m_irq = 1'b0;
`endif
    end else begin
      rd_e = bus.srd && !m_prev_rd;
      wr_e = bus.swr && !m_prev_wr;
      pre_busy = m_busy;
      if (rd_e) m_rdata = model_read(bus.saddress);
`ifdef GPIOEMU_MULPOP_IRQ_EN
      if (rd_e && bus.saddress == AD_CSR) m_irq = 1'b0;
`endif
      if (m_busy) begin
        m_t++;
        if (m_t == OP_W + 2) begin
          m_w = 32'(m_prod & ((64'd1 << RES_W) - 64'd1));
          m_l = 32'($countones(m_w));
          m_valid = ((m_prod >> RES_W) == 64'd0);
          m_cnt = (m_cnt + 1) % (1 << CNT_W);
          m_busy = 1'b0;
`ifdef GPIOEMU_MULPOP_IRQ_EN
          m_irq = 1'b1;
`endif
        end
      end
      if (wr_e) begin
        if (bus.saddress == AD_A1) m_a1 = bus.sdata_in[OP_W-1:0];
        else if (bus.saddress == AD_A2) m_a2 = bus.sdata_in[OP_W-1:0];
        else if (bus.saddress == AD_CSR && !pre_busy) begin
          m_busy = 1'b1;
          m_t = 0;
          m_prod = 64'(m_a1) * 64'(m_a2);
        end
      end
      if (gpio_latch) m_gpio_s = gpio_in;
      m_prev_rd = bus.srd;
      m_prev_wr = bus.swr;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("sdata_out", bus.sdata_out, m_rdata);
      check("gpio_out", gpio_out, 32'(m_cnt));
      check("gpio_in_s", gpio_in_s_insp, m_gpio_s);
      check("state", 32'(dbg_state), 32'(model_state()));
`ifdef GPIOEMU_MULPOP_IRQ_EN
      check("irq", 32'(irq), 32'(m_irq));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.saddress = a; bus.sdata_in = d; bus.swr = 1'b1;
    @(posedge clk); #1;
    bus.swr = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    bus.saddress = a; bus.srd = 1'b1;
    @(posedge clk); #1;
    bus.srd = 1'b0;
    d = bus.sdata_out;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    bus_write(AD_A1, a);
    bus_write(AD_A2, b);
    bus_write(AD_CSR, 32'h0);
    repeat (OP_W + 2) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  logic [15:0] addrs [7];

  initial begin
    reset = 1'b1; gpio_in = '0; gpio_latch = 1'b0;
    bus.saddress = '0; bus.srd = 1'b0; bus.swr = 1'b0; bus.sdata_in = '0;
    addrs[0] = AD_A1; addrs[1] = AD_A2; addrs[2] = AD_W; addrs[3] = AD_L;
    addrs[4] = AD_CSR; addrs[5] = 16'h03FC; addrs[6] = BASE + 16'h0004;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    cmp_en = 1'b1;

    // reset values
    bus_read(AD_CSR, rd); check("rst_csr", rd, 32'h1);
    bus_read(AD_W, rd);   check("rst_w", rd, 32'h0);
    check("rst_gpio_out", gpio_out, 32'h0);

    // 3 x 5 with latency pinned
    bus_write(AD_A1, 32'd3);
    bus_write(AD_A2, 32'd5);
    bus_write(AD_CSR, 32'h0);
    repeat (OP_W + 1) @(posedge clk);
    #1 check("lat_done_state", 32'(dbg_state), 32'(ST_DONE));
    @(posedge clk); #1;
    check("lat_idle_state", 32'(dbg_state), 32'(ST_IDLE));
    bus_read(AD_W, rd);   check("w_3x5", rd, 32'h0000000F);
    bus_read(AD_L, rd);   check("l_3x5", rd, 32'd4);
    bus_read(AD_CSR, rd); check("csr_3x5", rd, 32'h1);
    check("cnt_3x5", gpio_out, 32'd1);

    // overflow then recovery
    run_op(32'hFFFFFF, 32'hFFFFFF);
    bus_read(AD_W, rd);   check("w_ovf", rd, 32'hFE000001);
    bus_read(AD_L, rd);   check("l_ovf", rd, 32'd8);
    bus_read(AD_CSR, rd); check("csr_ovf", rd, 32'h0);
    run_op(32'd2, 32'd3);
    bus_read(AD_CSR, rd); check("csr_after_ovf", rd, 32'h1);
    bus_read(AD_W, rd);   check("w_2x3", rd, 32'd6);

    // second start and A1 rewrite while busy
    bus_write(AD_A1, 32'd10);
    bus_write(AD_A2, 32'd20);
    bus_write(AD_CSR, 32'h0);
    repeat (2) @(posedge clk);
    bus_write(AD_CSR, 32'h0);
    bus_write(AD_A1, 32'd99);
    repeat (OP_W + 4) @(posedge clk);
    #1;
    bus_read(AD_W, rd);  check("w_snapshot", rd, 32'd200);
    check("cnt_single_inc", gpio_out, 32'd4);
    bus_read(AD_A1, rd); check("a1_rewritten", rd, 32'd99);

    // reset in the middle of MULT
    bus_write(AD_CSR, 32'h0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    bus_read(AD_W, rd);   check("w_abort", rd, 32'h0);
    bus_read(AD_L, rd);   check("l_abort", rd, 32'h0);
    bus_read(AD_CSR, rd); check("csr_abort", rd, 32'h1);
    check("cnt_abort", gpio_out, 32'h0);
    run_op(32'd7, 32'd9);
    bus_read(AD_W, rd);   check("w_7x9", rd, 32'd63);
    bus_read(AD_L, rd);   check("l_7x9", rd, 32'd6);

    // counter wrap with CNT_W=4
    do_reset(2);
    for (int i = 0; i < 16; i++) run_op($urandom, $urandom);
    check("cnt_wrap", gpio_out, 32'h0);

    // srd held high: single read, value taken at the rising edge
    bus_write(AD_A1, 32'h123);
    @(posedge clk); #1;
    bus.saddress = AD_A1; bus.srd = 1'b1;
    @(posedge clk); #1;
    bus.sdata_in = 32'h55; bus.swr = 1'b1;
    @(posedge clk); #1;
    bus.swr = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.srd = 1'b0;
    check("srd_held_once", bus.sdata_out, 32'h123);

    // unmapped and read-only addresses
    bus_read(16'h03FC, rd); check("unmapped_rd", rd, 32'h0);
    bus_read(AD_W, rd);
    begin
      logic [31:0] w_before;
      w_before = rd;
      bus_write(AD_W, 32'h1234);
      bus_read(AD_W, rd); check("w_readonly", rd, w_before);
    end

    // read and write edges in the same cycle
    bus_write(AD_A2, 32'h777);
    @(posedge clk); #1;
    bus.saddress = AD_A2; bus.sdata_in = 32'h999; bus.srd = 1'b1; bus.swr = 1'b1;
    @(posedge clk); #1;
    bus.srd = 1'b0; bus.swr = 1'b0;
    check("rw_same_cycle", bus.sdata_out, 32'h777);
    bus_read(AD_A2, rd); check("rw_write_done", rd, 32'h999);

    // gpio capture
    @(posedge clk); #1;
    gpio_in = 32'hDEADBEEF; gpio_latch = 1'b1;
    @(posedge clk); #1;
    gpio_latch = 1'b0; gpio_in = 32'h0;
    @(posedge clk); #1;
    check("gpio_latch", gpio_in_s_insp, 32'hDEADBEEF);

    // randomized traffic, checked every cycle against the model
    for (int i = 0; i < 300; i++) begin
      int k;
      k = $urandom_range(0, 6);
      gpio_in = $urandom;
      gpio_latch = 1'($urandom_range(0, 1));
      case (k)
        0: bus_write(AD_A1, ($urandom_range(0, 3) == 0) ? 32'hFFFFFF : $urandom);
        1: bus_write(AD_A2, ($urandom_range(0, 3) == 0) ? 32'(($urandom_range(0, 255))) : $urandom);
        2: bus_write(AD_CSR, $urandom);
        3: bus_read(addrs[$urandom_range(0, 6)], rd);
        4: begin
          @(posedge clk); #1;
          bus.saddress = addrs[$urandom_range(0, 6)];
          bus.sdata_in = $urandom;
          bus.srd = 1'($urandom_range(0, 1));
          bus.swr = 1'($urandom_range(0, 1));
          repeat ($urandom_range(1, 4)) @(posedge clk);
          #1 bus.srd = 1'b0; bus.swr = 1'b0;
        end
        5: bus_write(addrs[$urandom_range(5, 6)], $urandom);
        default: begin
          repeat ($urandom_range(1, 12)) @(posedge clk);
          #1;
        end
      endcase
    end
    gpio_latch = 1'b0;
    repeat (OP_W + 4) @(posedge clk);
    #1;

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
